// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types for the ALU command arbiter.
// Command word layout is {op, addr1, addr2, addr3}, three bits per field.
package alu_arb_pkg;

    localparam int CMD_W = 12;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b011,
        CAS = 3'b111
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [2:0] addr1;
        logic [2:0] addr2;
        logic [2:0] addr3;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_cmd_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority selector.
// Searches upward from ptr with wrap-around and returns the first set request
// as a one-hot grant, its index, and whether any request was present.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Two descending passes: the wrapped region below ptr first, then the region
    // at/above ptr, so a hit at/above ptr always overrides and the lowest index wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k] && (k < int'(ptr))) begin
                idx = IW'(k);
                any = 1'b1;
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k] && (k >= int'(ptr))) begin
                idx = IW'(k);
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_arbiter.sv
// alu_cmd_arbiter: round-robin arbiter giving NUM_REQ requesters atomic,
// one-at-a-time access to a shared ALU (IDLE -> ISSUE -> WAIT -> RESP).
// Optional WAIT watchdog is compiled in when ALU_ARB_TIMEOUT_EN is defined;
// otherwise WAIT is unbounded and rsp_err is tied low.
module alu_cmd_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][CMD_W-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic                            rsp_err,
    output logic [CMD_W-1:0]                alu_cmd,
    output logic                            alu_run,
    input  logic                            alu_done,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      owner
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner_q;
    alu_cmd_t           cmd_q;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               timeout_hit;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = (state == RESP) && err_q;

    // Watchdog: count WAIT cycles from zero and remember whether WAIT was left by timeout;
    // a done arriving on the limit cycle takes precedence over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ISSUE: begin
                    wait_cnt <= '0;
                    err_q    <= 1'b0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    err_q    <= timeout_hit && !alu_done;
                end
                default: ;
            endcase
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign alu_cmd = cmd_q;
    assign owner   = owner_q;

    // State register for the transaction sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and strobes; grants are only offered in IDLE and never while in reset.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        alu_run    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (rst_n) begin
                    req_ready = pick_grant;
                end
                if (pick_any) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                alu_run    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (alu_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the winner's command and index at acceptance, and rotate priority past the
    // owner once its response goes out so every active requester gets a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            owner_q <= '0;
            cmd_q   <= '0;
        end else begin
            if ((state == IDLE) && pick_any) begin
                cmd_q   <= alu_cmd_t'(req_cmd[pick_idx]);
                owner_q <= pick_idx;
            end
            if (state == RESP) begin
                rr_ptr <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_arbiter.sv
// tb_alu_cmd_arbiter: self-checking bench for alu_cmd_arbiter.
// A transaction-level model (accept time, done time, round-robin pointer) predicts
// every output each cycle; directed scenarios are followed by a randomized phase.
// Define ALU_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_alu_cmd_arbiter;
    import alu_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0]          req_valid;
    logic [N-1:0][11:0]    req_cmd;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          rsp_valid;
    logic                  rsp_err;
    logic [11:0]           alu_cmd;
    logic                  alu_run;
    logic                  alu_done;
    logic                  busy;
    logic [1:0]            owner;

    // Free-running clock.
    always #5 clk = ~clk;

    alu_cmd_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .alu_cmd   (alu_cmd),
        .alu_run   (alu_run),
        .alu_done  (alu_done),
        .busy      (busy),
        .owner     (owner)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Transaction-level model state.
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_t_acc;
    int          m_t_done;
    bit          m_err;
    logic [11:0] m_cmd;
    int          m_just_acc;
    int          cyc = 0;

    int run_seen = 0;
    int rsp_seen = 0;

    logic [N-1:0][11:0] cmd_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit model_in_wait();
        return m_busy && (m_t_done < 0) && (cyc >= m_t_acc + 2);
    endfunction

    function automatic void model_reset();
        m_busy     = 1'b0;
        m_owner    = 0;
        m_ptr      = 0;
        m_t_acc    = -10;
        m_t_done   = -1;
        m_err      = 1'b0;
        m_cmd      = '0;
        m_just_acc = -1;
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    function automatic void model_step();
        int w;
        m_just_acc = -1;
        if (rst_n) begin
            if (!m_busy) begin
                w = model_winner();
                if (w >= 0) begin
                    m_busy     = 1'b1;
                    m_owner    = w;
                    m_cmd      = req_cmd[w];
                    m_t_acc    = cyc;
                    m_t_done   = -1;
                    m_err      = 1'b0;
                    m_just_acc = w;
                end
            end else if (m_t_done >= 0) begin
                if (cyc == m_t_done + 1) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end else if (cyc >= m_t_acc + 2) begin
                if (alu_done) begin
                    m_t_done = cyc;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (cyc - (m_t_acc + 2) == TO - 1) begin
                    m_t_done = cyc;
                    m_err    = 1'b1;
                end
`endif
            end
        end
        cyc++;
    endfunction

    task automatic checkOutput();
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        logic         e_run;
        logic         e_busy;
        logic         e_err;
        int           w;
        e_ready = '0;
        e_rsp   = '0;
        e_run   = 1'b0;
        e_busy  = 1'b0;
        e_err   = 1'b0;
        if (rst_n) begin
            if (!m_busy) begin
                w = model_winner();
                if (w >= 0) e_ready[w] = 1'b1;
            end else begin
                e_busy = 1'b1;
                e_run  = (cyc == m_t_acc + 1);
                if ((m_t_done >= 0) && (cyc == m_t_done + 1)) begin
                    e_rsp[m_owner] = 1'b1;
                    e_err          = m_err;
                end
            end
        end
        if (alu_run === 1'b1) run_seen++;
        if (|rsp_valid) rsp_seen++;
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("alu_run",   32'(alu_run),   32'(e_run));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        check("rsp_err",   32'(rsp_err),   32'(e_err));
        check("busy",      32'(busy),      32'(e_busy));
        check("owner",     32'(owner),     32'(m_owner));
        check("alu_cmd",   32'(alu_cmd),   32'(m_cmd));
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic d);
        @(negedge clk);
        req_cmd   = cmd_next;
        req_valid = v;
        alu_done  = d;
        #1;
        checkOutput();
        model_step();
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        alu_done  = 1'b0;
        #1;
        model_reset();
        checkOutput();
        check("reset_busy",    32'(busy),      32'd0);
        check("reset_run",     32'(alu_run),   32'd0);
        check("reset_rsp",     32'(rsp_valid), 32'd0);
        check("reset_alu_cmd", 32'(alu_cmd),   32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 40) begin
            applyStimulus('0, model_in_wait());
            n++;
        end
        check("drain_idle", 32'(m_busy), 32'd0);
    endtask

    initial begin
        int          grants[$];
        int          gap;
        bit          seen;
        logic [N-1:0] v;
        int          exp_order[5];

        cmd_next  = '0;
        req_cmd   = '0;
        req_valid = '0;
        alu_done  = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};

        $display("[TB] reset");
        doReset();

        $display("[TB] single request timeline");
        cmd_next[0] = 12'b000_001_010_000;
        applyStimulus(4'b0001, 1'b0);
        check("single_ready", 32'(req_ready), 32'h1);
        applyStimulus(4'b0000, 1'b0);
        check("single_run", 32'(alu_run), 32'h1);
        check("single_cmd", 32'(alu_cmd), 32'h050);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        check("single_rsp", 32'(rsp_valid), 32'h1);
        check("single_err", 32'(rsp_err),   32'h0);

        $display("[TB] round robin from reset");
        doReset();
        for (int i = 0; i < N; i++) cmd_next[i] = 12'($urandom);
        for (int t = 0; t < 40 && grants.size() < 5; t++) begin
            applyStimulus(4'hF, model_in_wait());
            for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) grants.push_back(i);
        end
        check("rr_grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_order", 32'(grants[i]), 32'(exp_order[i]));
        drain();

        $display("[TB] late request held off during WAIT");
        applyStimulus(4'b0001, 1'b0);
        check("hold_ready0", 32'(req_ready), 32'h1);
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0100, 1'b0);
            check("hold_no_ready", 32'(req_ready), 32'h0);
        end
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        check("hold_rsp0", 32'(rsp_valid), 32'h1);
        check("hold_resp_ready", 32'(req_ready), 32'h0);
        applyStimulus(4'b0100, 1'b0);
        check("hold_ready2", 32'(req_ready), 32'h4);
        drain();
        check("run_rsp_balance", 32'(run_seen), 32'(rsp_seen));

        $display("[TB] stray alu_done in IDLE and ISSUE");
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        cmd_next[1] = 12'($urandom);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        check("stray_busy", 32'(busy), 32'h1);
        check("stray_no_rsp", 32'(rsp_valid), 32'h0);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        check("stray_rsp", 32'(rsp_valid), 32'h2);

        $display("[TB] reset during WAIT");
        cmd_next[1] = 12'b111_001_010_011;
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        check("rst_cmd_before", 32'(alu_cmd), 32'hE53);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        #2;
        doReset();
        applyStimulus(4'b1000, 1'b0);
        check("rst_after_ready3", 32'(req_ready), 32'h8);
        drain();

`ifdef ALU_ARB_TIMEOUT_EN
        $display("[TB] watchdog");
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(4'b0001, 1'b0);
            gap  = 0;
            seen = 1'b0;
            for (int t = 1; t < 20 && !seen; t++) begin
                applyStimulus(4'b0000, (pass == 1) && (t == 9));
                if (rsp_valid !== '0) begin
                    seen = 1'b1;
                    gap  = t;
                    check("wd_err", 32'(rsp_err), (pass == 0) ? 32'd1 : 32'd0);
                end
            end
            check("wd_gap", 32'(gap), 32'd10);
            drain();
        end
`endif

        $display("[TB] randomized traffic");
        v = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_just_acc == i) begin
                    v[i] = 1'b0;
                end else if (v[i]) begin
                    if ($urandom_range(0, 15) == 0) v[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    v[i]        = 1'b1;
                    cmd_next[i] = 12'($urandom);
                end
            end
            applyStimulus(v, $urandom_range(0, 3) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
